// File: rtl/fir_int4_ctrl.sv
// Control wrapper for a x4 FIR: burst FSM, zero-flush injection and {valid,last} tag line; FIR_CTRL_UNDERFLOW_EN makes input gaps keep output contiguous and raise sticky underflow.
// Input-to-output latency LATENCY cycles; s_axis_tready drops during flush/drain, no output backpressure.
module fir_int4_ctrl #(
  parameter int LATENCY   = 20,
  parameter int FLUSH_LEN = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  input  logic         s_axis_tlast,
  output logic         s_axis_tready,
  output logic [127:0] fir_din,
  input  logic [511:0] fir_dout,
  output logic [511:0] m_axis_tdata,
  output logic         m_axis_tvalid,
  output logic         m_axis_tlast,
  input  logic         underflow_clr,
  output logic         underflow,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  localparam logic [6:0] FLUSH_LAST = 7'(FLUSH_LEN - 1);

  state_t               r_state;
  logic [6:0]           r_flush_cnt;
  logic [127:0]         r_fir_din;
  logic [LATENCY-1:0]   r_tag_vld;
  logic [LATENCY-1:0]   r_tag_last;

  logic w_accept;
  logic w_flush;
  logic w_tag_vld;
  logic w_tag_last;

  assign s_axis_tready = ~rst & ((r_state == IDLE) | (r_state == RUN));
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_flush       = (r_state == FLUSH);
  assign w_tag_last    = w_flush & (r_flush_cnt == FLUSH_LAST);

`ifdef FIR_CTRL_UNDERFLOW_EN
  logic w_gap;
  logic r_underflow;

  assign w_gap     = (r_state == RUN) & ~s_axis_tvalid;
  assign w_tag_vld = w_accept | w_flush | w_gap;
  assign underflow = r_underflow;

  // Sticky flag: a new gap outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_underflow <= 1'b0;
    end else if (w_gap) begin
      r_underflow <= 1'b1;
    end else if (underflow_clr) begin
      r_underflow <= 1'b0;
    end
  end
`else
  logic w_unused_clr;

  assign w_tag_vld    = w_accept | w_flush;
  assign underflow    = 1'b0;
  assign w_unused_clr = underflow_clr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_flush_cnt <= '0;
      r_fir_din   <= '0;
      r_tag_vld   <= '0;
      r_tag_last  <= '0;
    end else begin
      r_fir_din  <= w_accept ? s_axis_tdata : '0;
      r_tag_vld  <= {r_tag_vld[LATENCY-2:0], w_tag_vld};
      r_tag_last <= {r_tag_last[LATENCY-2:0], w_tag_last};
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_flush_cnt <= '0;
            r_state     <= s_axis_tlast ? FLUSH : RUN;
          end
        end
        RUN: begin
          if (w_accept && s_axis_tlast) begin
            r_flush_cnt <= '0;
            r_state     <= FLUSH;
          end
        end
        FLUSH: begin
          if (r_flush_cnt == FLUSH_LAST) begin
            r_state <= DRAIN;
          end else begin
            r_flush_cnt <= r_flush_cnt + 7'd1;
          end
        end
        DRAIN: begin
          // Leave once the final flush tag has reached the output.
          if (r_tag_last[LATENCY-1]) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fir_din       = r_fir_din;
  assign m_axis_tdata  = fir_dout;
  assign m_axis_tvalid = r_tag_vld[LATENCY-1];
  assign m_axis_tlast  = r_tag_last[LATENCY-1];
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_fir_int4_ctrl.sv
// Directed bench for fir_int4_ctrl: per-cycle stimulus tables checked against a burst-level timing model.
module tb_fir_int4_ctrl;

  localparam int LAT = 20;
  localparam int FL  = 8;
  localparam int NMAX = 64;
`ifdef FIR_CTRL_UNDERFLOW_EN
  localparam bit UF = 1'b1;
`else
  localparam bit UF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [127:0] fir_din;
  logic [511:0] fir_dout;
  logic [511:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         underflow_clr;
  logic         underflow;
  logic         busy;

  fir_int4_ctrl #(.LATENCY(LAT), .FLUSH_LEN(FL)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .fir_din(fir_din), .fir_dout(fir_dout),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .underflow_clr(underflow_clr),
    .underflow(underflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Stimulus tables
  bit           sv [NMAX];
  bit           sl [NMAX];
  bit           sr [NMAX];
  bit           sc [NMAX];
  logic [127:0] sd [NMAX];
  // Expected outputs
  bit           ev [NMAX];
  bit           el [NMAX];
  bit           er [NMAX];
  bit           eb [NMAX];
  bit           eu [NMAX];
  logic [127:0] ed [NMAX];

  int tid;
  int late_last;

  task automatic chk(input string nm, input int cyc, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL t%0d %s cyc=%0d got=%0h want=%0h", tid, nm, cyc, act, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NMAX; i++) begin
      sv[i] = 1'b0; sl[i] = 1'b0; sr[i] = 1'b0; sc[i] = 1'b0; sd[i] = '0;
    end
  endtask

  // Burst-level model: locate start S, tlast beat E and first reset R, then
  // derive every output from those positions.
  task automatic build_model(input int nc);
    int  s, e, r, d;
    bit  acc [NMAX];
    bit  tag [NMAX];
    bit  gap;
    s = NMAX; e = NMAX; r = NMAX;
    for (int c = nc - 1; c >= 0; c--) begin
      if (sv[c]) s = c;
      if (sr[c]) r = c;
    end
    for (int c = nc - 1; c >= s; c--) if (sv[c] && sl[c]) e = c;
    d = e + FL + LAT;
    eu[0] = 1'b0;
    for (int c = 0; c < nc; c++) begin
      acc[c] = (c >= s) && (c <= e) && sv[c];
      gap    = (c > s) && (c < e) && !sv[c];
      tag[c] = acc[c] || ((c > e) && (c <= e + FL)) || (UF && gap);
      er[c]  = !sr[c] && !((c > e) && (c <= d));
      eb[c]  = (c > s) && (c <= d);
      ed[c]  = (c > 0 && acc[c-1]) ? sd[c-1] : '0;
      ev[c]  = (c >= LAT) ? tag[c-LAT] : 1'b0;
      el[c]  = (c == d);
      if (c + 1 < NMAX) eu[c+1] = (UF && gap) ? 1'b1 : (sc[c] ? 1'b0 : eu[c]);
    end
    for (int c = r + 1; c < nc; c++) begin
      ev[c] = 1'b0; el[c] = 1'b0; eb[c] = 1'b0; eu[c] = 1'b0; ed[c] = '0; er[c] = 1'b1;
    end
  endtask

  function automatic int count_ev(input int nc);
    int n = 0;
    for (int c = 0; c < nc; c++) if (ev[c]) n++;
    return n;
  endfunction

  task automatic do_reset();
    rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
    underflow_clr = 1'b0; fir_dout = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_tready", -1, s_axis_tready, 0);
    chk("rst_tvalid", -1, m_axis_tvalid, 0);
    chk("rst_tlast",  -1, m_axis_tlast, 0);
    chk("rst_busy",   -1, busy, 0);
    chk("rst_uf",     -1, underflow, 0);
    chk("rst_din",    -1, fir_din, 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run(input int nc);
    late_last = 0;
    for (int c = 0; c < nc; c++) begin
      rst           = sr[c];
      s_axis_tvalid = sv[c];
      s_axis_tlast  = sl[c];
      s_axis_tdata  = sd[c];
      underflow_clr = sc[c];
      fir_dout      = {16{32'(c) * 32'h0101_0101 + 32'h1357_0001}};
      @(negedge clk);
      chk("tvalid", c, m_axis_tvalid, ev[c]);
      chk("tlast",  c, m_axis_tlast,  el[c]);
      chk("tready", c, s_axis_tready, er[c]);
      chk("busy",   c, busy,          eb[c]);
      chk("uf",     c, underflow,     eu[c]);
      chk("din",    c, fir_din,       ed[c]);
      chk("tdata",  c, m_axis_tdata,  fir_dout);
      // Hand-computed anchors
      if (tid == 0 && c == 37) chk("lit_tlast37", c, m_axis_tlast, 1);
      if (tid == 0 && c == 38) chk("lit_busy38",  c, busy, 0);
      if (tid == 0 && c == 10) chk("lit_rdy10",   c, s_axis_tready, 0);
      if (tid == 0 && c == 14) chk("lit_din14",   c, fir_din, 0);
      if (tid == 1 && c == 25) chk("lit_gap25",   c, m_axis_tvalid, UF);
      if (tid == 1 && c == 6)  chk("lit_uf6",     c, underflow, UF);
      if (tid == 2 && c == 28) chk("lit_tlast28", c, m_axis_tlast, 1);
      if (tid == 2 && c == 29) chk("lit_tv29",    c, m_axis_tvalid, 0);
      if (tid == 3 && c == 16) chk("lit_busy16",  c, busy, 0);
      if (tid == 3 && c > 15 && m_axis_tlast) late_last++;
      if (tid == 4 && c == 8)  chk("lit_uf8",     c, underflow, UF);
      if (tid == 4 && c == 11) chk("lit_uf11",    c, underflow, 0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // A: 10 beats, tlast on the 10th, constant data held through flush
    tid = 0;
    clear_stim();
    for (int i = 0; i < NMAX; i++) sd[i] = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
    for (int i = 0; i < 10; i++) sv[i] = 1'b1;
    sl[9] = 1'b1;
    build_model(45);
    chk("model_cnt_a", 0, count_ev(45), 18);
    chk("model_last_a", 0, el[37], 1);
    do_reset();
    run(45);

    // B: gap at cycle 5
    tid = 1;
    clear_stim();
    for (int i = 0; i < NMAX; i++) sd[i] = {4{i[15:0] + 16'hA000, ~i[15:0]}};
    for (int i = 0; i < 10; i++) sv[i] = (i != 5);
    sl[9] = 1'b1;
    build_model(45);
    chk("model_cnt_b", 0, count_ev(45), UF ? 18 : 17);
    do_reset();
    run(45);

    // C: single beat with tlast from IDLE
    tid = 2;
    clear_stim();
    for (int i = 0; i < NMAX; i++) sd[i] = {4{16'h5A00 + i[15:0], 16'h0C00 + i[15:0]}};
    sv[0] = 1'b1; sl[0] = 1'b1;
    build_model(35);
    chk("model_cnt_c", 0, count_ev(35), 9);
    do_reset();
    run(35);

    // D: burst A aborted by reset at cycle 15
    tid = 3;
    clear_stim();
    for (int i = 0; i < NMAX; i++) sd[i] = {8{i[15:0] ^ 16'h3C3C}};
    for (int i = 0; i < 10; i++) sv[i] = 1'b1;
    sl[9] = 1'b1;
    sr[15] = 1'b1;
    build_model(45);
    do_reset();
    run(45);
    chk("late_tlast", 45, late_last, 0);

    // E: idle wait, gaps at 5 and 7, clear during gap 7 and again at 10
    tid = 4;
    clear_stim();
    for (int i = 0; i < NMAX; i++) sd[i] = {4{16'hBEEF ^ i[15:0], 16'h0100 + i[15:0]}};
    for (int i = 3; i <= 12; i++) sv[i] = (i != 5) && (i != 7);
    sl[12] = 1'b1;
    sc[7]  = 1'b1;
    sc[10] = 1'b1;
    build_model(50);
    do_reset();
    run(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_int4_ctrl.md
FIR_INT4_CTRL -- requirements
Module: fir_int4_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 20: cycles from an accepted input beat to its output beat through this block plus the x4 FIR datapath; legal range 2..256.
REQ-002 SHALL have parameter FLUSH_LEN, default 8: zero beats injected after the last input beat; legal range 1..64.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk in, rst in.
REQ-004 SHALL have the following ports (name, direction, width, meaning), one per line:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  s_axis_tdata  in  128  4 complex samples, {Q,I} 16+16 each
  s_axis_tvalid  in  1  input beat valid
  s_axis_tlast  in  1  last beat of burst
  s_axis_tready  out  1  input accepted
  fir_din  out  128  samples to FIR datapath
  fir_dout  in  512  16 complex samples from FIR datapath
  m_axis_tdata  out  512  output samples
  m_axis_tvalid  out  1  output beat valid
  m_axis_tlast  out  1  last output beat of burst
  underflow_clr  in  1  clears sticky underflow
  underflow  out  1  sticky input-gap flag
  busy  out  1  state != IDLE

Function
REQ-005 SHALL implement the FSM states IDLE, RUN, FLUSH and DRAIN.
REQ-006 SHALL drive s_axis_tready=1 in IDLE and RUN, and s_axis_tready=0 in FLUSH and DRAIN; accept = s_axis_tvalid & s_axis_tready.
REQ-007 SHALL make the following IDLE transitions: on accept without tlast -> RUN; on accept with tlast -> FLUSH; otherwise stay in IDLE.
REQ-008 SHALL make the following RUN transition: on accept with tlast -> FLUSH.
REQ-009 SHALL stay in FLUSH for exactly FLUSH_LEN cycles, then move to DRAIN.
REQ-010 SHALL stay in DRAIN until the tag of the last flush beat has emitted m_axis_tlast, then move to IDLE in the following cycle.
REQ-011 SHALL register fir_din each cycle: s_axis_tdata on accept, otherwise all zeros; this applies to gap, flush, drain and idle cycles.
REQ-012 SHALL delay a per-cycle tag {valid,last} through a shift line so that a tag entering at cycle N appears on m_axis_tvalid/m_axis_tlast at cycle N+LATENCY.
REQ-013 SHALL set tag valid=1 for accepted beats and for flush beats, and tag valid=0 in IDLE and DRAIN.
REQ-014 SHALL set tag last=1 only on the final flush beat.
REQ-015 SHALL drive m_axis_tdata combinationally from fir_dout; the block applies no output backpressure.
REQ-016 SHALL treat a RUN cycle with s_axis_tvalid=0 as a gap: a zero beat is injected into fir_din.
REQ-017 SHALL, when underflow_clr and a new gap occur in the same cycle, let the set win.
REQ-018 SHALL keep busy=1 from the cycle after the first accept through the last DRAIN cycle.

Reset
REQ-019 SHALL, on rst=1, at the next edge: state=IDLE; tag line, flush counter and fir_din cleared; s_axis_tready=0 during rst; m_axis_tvalid, m_axis_tlast, underflow and busy all 0.
REQ-020 SHALL, on reset mid-burst, abort the burst: no m_axis_tvalid and no m_axis_tlast from pre-reset beats are emitted.

Configuration
REQ-021 SHALL support the macro FIR_CTRL_UNDERFLOW_EN.
REQ-022 SHALL, with FIR_CTRL_UNDERFLOW_EN defined, tag gap beats valid=1 so the output stays contiguous, and set underflow sticky on a gap.
REQ-023 SHALL, without FIR_CTRL_UNDERFLOW_EN defined, tag gap beats valid=0, tie underflow to 0, and ignore underflow_clr.

Verification
REQ-024 SHALL cover: 10 contiguous beats at cycles 0-9, tlast on beat 10 -> m_axis_tvalid high cycles 20-37, m_axis_tlast at 37, s_axis_tready low 10-37, busy low from 38.
REQ-025 SHALL cover: beats 0-4, gap at cycle 5, beats 6-9 with tlast on 9 -> with macro: m_axis_tvalid contiguous 20-37 and underflow=1 from cycle 6; without macro: m_axis_tvalid low at 25 only and underflow=0.
REQ-026 SHALL cover: single beat with tlast in IDLE at cycle 0 -> state FLUSH, m_axis_tvalid high cycles 20-28, m_axis_tlast at 28.
REQ-027 SHALL cover: rst pulsed at cycle 15 during the REQ-024 burst -> from cycle 16 all outputs 0, fir_din=0, and m_axis_tlast never asserts.
REQ-028 SHALL cover: underflow=1 with underflow_clr=1 during a gap cycle -> underflow stays 1; underflow_clr=1 in a non-gap cycle -> underflow=0 next cycle.
REQ-029 SHALL cover: s_axis_tdata=0x1234... held throughout flush -> fir_din=0 for all 8 flush cycles.
